// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 2:1 output mux. Grants one of two
// requesters, handshakes beats downstream, and caps each grant at MAX_BURST beats.
module mux_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic [W-1:0] data_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [W-1:0] data_b,
  output logic         ack_b,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state, state_nx;
  logic          sel_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last, last_nx;   // 0 = A served last, 1 = B served last

  logic req_g, req_o, xfer, burst_done, rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    req_g      = 1'b0;
    req_o      = 1'b0;
    case (state)
      GNT_A:   begin req_g = req_a; req_o = req_b; end
      GNT_B:   begin req_g = req_b; req_o = req_a; end
      default: begin req_g = 1'b0;  req_o = 1'b0;  end
    endcase
    busy       = (state != IDLE);
    out_valid  = busy & req_g;
    out_data   = out_valid ? (sel ? data_b : data_a) : '0;
    xfer       = out_valid & out_ready;
    ack_a      = xfer & (state == GNT_A);
    ack_b      = xfer & (state == GNT_B);
    burst_done = xfer & (cnt == CW'(MAX_BURST - 1));
    rel        = busy & (burst_done | ~req_g);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        // on a tie, the side not served last wins
        if (req_a && (!req_b || last)) state_nx = GNT_A;
        else if (req_b)                state_nx = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (rel) begin
          last_nx = (state == GNT_B);
          cnt_nx  = '0;
          if (req_o)      state_nx = (state == GNT_A) ? GNT_B : GNT_A;
          else if (req_g) state_nx = state;
          else            state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(xfer);
        end
      end
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      GNT_A:   sel_nx = 1'b0;
      GNT_B:   sel_nx = 1'b1;
      default: sel_nx = sel;
    endcase
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: per-cycle expected handshake/select values.
module tb_mux_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst, req_a, req_b, out_ready;
  logic [7:0] data_a, data_b, out_data;
  logic       ack_a, ack_b, out_valid, sel, busy;
  int         n_chk = 0;
  int         n_fail = 0;

  mux_rr_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // check all outputs mid-cycle, then advance past the next rising edge
  task automatic cyc(input string tag, input logic ea, input logic eb, input logic es,
                     input logic ev, input logic eby, input logic [7:0] ed);
    @(negedge clk);
    chk({tag, ".ack_a"},     32'(ack_a),     32'(ea));
    chk({tag, ".ack_b"},     32'(ack_b),     32'(eb));
    chk({tag, ".sel"},       32'(sel),       32'(es));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".busy"},      32'(busy),      32'(eby));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    data_a = 8'hA5; data_b = 8'h5A;

    // 1: reset held two cycles with both requesting
    @(posedge clk); #1;
    cyc("rst0", 0, 0, 0, 0, 0, 8'h00);
    cyc("rst1", 0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;

    // 2: A alone, continuous; no bubble at burst boundary
    req_b = 1'b0;
    cyc("a_only_idle", 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) cyc("a_only", 1, 0, 0, 1, 1, 8'hA5);
    req_a = 1'b0;
    cyc("a_withdraw", 0, 0, 0, 0, 1, 8'h00);
    cyc("a_idle", 0, 0, 0, 0, 0, 8'h00);

    // 3: both requesting continuously -> AAAABBBBAAAA
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    cyc("rr_idle", 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      if (i >= 4 && i < 8) cyc("rr_b", 0, 1, 1, 1, 1, 8'h5A);
      else                 cyc("rr_a", 1, 0, 0, 1, 1, 8'hA5);
    end

    // 4: backpressure mid-burst holds count, select and data
    do_reset();
    cyc("bp_idle", 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) cyc("bp_a_pre", 1, 0, 0, 1, 1, 8'hA5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("bp_stall", 0, 0, 0, 1, 1, 8'hA5);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) cyc("bp_a_post", 1, 0, 0, 1, 1, 8'hA5);
    cyc("bp_switch_b", 0, 1, 1, 1, 1, 8'h5A);

    // 5: A withdraws after 2 beats; B gets a full burst
    do_reset();
    cyc("wd_idle", 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) cyc("wd_a", 1, 0, 0, 1, 1, 8'hA5);
    req_a = 1'b0;
    cyc("wd_drop", 0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) cyc("wd_b", 0, 1, 1, 1, 1, 8'h5A);
    req_a = 1'b1;
    cyc("wd_b4", 0, 1, 1, 1, 1, 8'h5A);
    cyc("wd_back_a", 1, 0, 0, 1, 1, 8'hA5);

    // 6: reset mid GNT_B burst; A wins first afterwards
    do_reset();
    cyc("mr_idle", 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc("mr_a", 1, 0, 0, 1, 1, 8'hA5);
    for (int i = 0; i < 2; i++) cyc("mr_b", 0, 1, 1, 1, 1, 8'h5A);
    do_reset();
    cyc("mr_after_rst", 0, 0, 0, 0, 0, 8'h00);
    cyc("mr_a_first", 1, 0, 0, 1, 1, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
